// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared defaults and state encoding for the
// DAC stream transmitter.
package dac_tx_pkg;
    localparam int         DATA_W_DEF   = 8;
    localparam logic [7:0] MIDSCALE_DEF = 8'h80;
    localparam int         UF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;
endpackage

// File: rtl/dac_stream_tx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with
// registered full flag and occupancy count.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && (level_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
        full_d = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (level_q == '0);
    assign level = level_q;
endmodule

// File: rtl/dac_stream_tx.sv
// dac_stream_tx: buffers processed samples and streams them to
// the parallel DAC with a programmable daclk divider.
module dac_stream_tx
    import dac_tx_pkg::*;
#(
    parameter  int                DATA_W      = DATA_W_DEF,
    parameter  int                FIFO_DEPTH  = 16,
    parameter  int                DIV_W       = 8,
    parameter  logic [DATA_W-1:0] MIDSCALE    = DATA_W'(MIDSCALE_DEF),
    parameter  int                PRIME_LEVEL = 8,
    localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                global_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DATA_W-1:0]   daout_data,
    output logic                daclk,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] underflow_count,
    output logic [LVL_W-1:0]    fifo_level
);
    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d, div_eff;
    logic                daclk_q, daclk_d;
    logic                uf_q, uf_d;
    logic [DATA_W-1:0]   dout_q, dout_d, head;
    logic [UF_CNT_W-1:0] ucnt_q, ucnt_d;
    logic                pop, empty, full;
    logic                terminal, tick, prime_go;

    sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk  (global_clk),
        .reset(reset),
        .push (s_valid),
        .din  (s_data),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );

    // div_q holds the half-period latched at the last terminal count.
    always_comb begin
        div_eff  = (clk_div == '0) ? DIV_W'(1) : clk_div;
        terminal = (cnt_q >= div_q - DIV_W'(1));
        tick     = (state_q == ST_RUN) && terminal && daclk_q;
        prime_go = (state_q == ST_PRIME) && enable
                 && (fifo_level >= LVL_W'(PRIME_LEVEL));
    end

    always_ff @(posedge global_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(1);
            daclk_q <= 1'b0;
            dout_q  <= MIDSCALE;
            uf_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            daclk_q <= daclk_d;
            dout_q  <= dout_d;
            uf_q    <= uf_d;
            ucnt_q  <= ucnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable)       state_d = ST_IDLE;
                else if (prime_go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick && !enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        daclk_d = daclk_q;
        dout_d  = dout_q;
        uf_d    = 1'b0;
        ucnt_d  = ucnt_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (terminal) begin
                    cnt_d   = '0;
                    div_d   = div_eff;
                    daclk_d = !daclk_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                // Disable is honoured only on a falling edge so the
                // DAC never sees a truncated high phase.
                if (tick) begin
                    if (!enable) begin
                        dout_d  = MIDSCALE;
                        daclk_d = 1'b0;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        dout_d = head;
                    end else begin
                        uf_d = 1'b1;
                        if (ucnt_q != '1) ucnt_d = ucnt_q + UF_CNT_W'(1);
                    end
                end
            end
            ST_PRIME: begin
                daclk_d = 1'b0;
                if (prime_go) begin
                    pop    = 1'b1;
                    dout_d = head;
                    cnt_d  = '0;
                    div_d  = div_eff;
                end else begin
                    dout_d = MIDSCALE;
                    cnt_d  = terminal ? '0 : cnt_q + DIV_W'(1);
                    div_d  = terminal ? div_eff : div_q;
                end
            end
            default: begin
                cnt_d   = '0;
                div_d   = div_eff;
                daclk_d = 1'b0;
                dout_d  = MIDSCALE;
            end
        endcase
    end

    assign s_ready         = !full;
    assign daout_data      = dout_q;
    assign daclk           = daclk_q;
    assign underflow       = uf_q;
    assign underflow_count = ucnt_q;
endmodule

// File: doc/dac_stream_tx.md
Name: dac_stream_tx

Overview:
- Transmit-side counterpart to the ADC capture path: streams processed 8-bit samples (e.g. FFT/filter results) out to the parallel DAC.
- Buffers samples in a small FIFO fed by a valid/ready handshake.
- Generates daclk as a programmable divide of global_clk and presents daout_data so it is stable across each daclk rising edge.
- Sits between the processing core and the daout_data/daclk pins in top.

Parameters:
- DATA_W, 8, sample width.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 4.
- DIV_W, 8, width of clk_div.
- MIDSCALE, 8'h80, DAC idle code.
- PRIME_LEVEL, 8, FIFO level required before streaming starts.

Ports:
- global_clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  streaming enable.
- clk_div  in  DIV_W  daclk half-period in global_clk cycles; 0 treated as 1.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept this cycle.
- daout_data  out  DATA_W  DAC data bus.
- daclk  out  1  DAC sample clock; DAC latches on rising edge.
- underflow  out  1  one-cycle pulse when an update finds the FIFO empty.
- underflow_count  out  16  saturating underflow counter.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous): FIFO flushed, fifo_level=0, s_ready=1, daout_data=MIDSCALE, daclk=0, underflow=0, underflow_count=0, state=IDLE, divider count=0.
- Reset asserted mid-stream has the same effect; buffered samples are discarded.
- Push: occurs when s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), registered. fifo_level reflects a push one cycle after acceptance.
- Simultaneous push and pop: level unchanged, data order preserved.
- Push while full: not possible because s_ready=0; s_data is ignored.
- FIFO ordering is strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH.
- Divider: count runs 0..max(clk_div,1)-1 in PRIME/RUN only. Each terminal count toggles daclk, so daclk period = 2*max(clk_div,1) cycles.
- Update tick: the cycle in which daclk toggles 1->0.
- State IDLE:
  - daclk=0, daout_data=MIDSCALE, divider held at 0; FIFO still accepts pushes.
  - enable=1 -> PRIME.
- State PRIME:
  - Outputs as in IDLE.
  - enable=0 -> IDLE.
  - fifo_level >= PRIME_LEVEL -> RUN. On that transition cycle, pop the head into daout_data, keep daclk=0, and reset the divider.
- State RUN:
  - daclk rises clk_div cycles after the transition; daout_data is therefore always stable for clk_div cycles before each rising edge.
  - At each update tick, if FIFO is non-empty: pop the head into daout_data.
  - At each update tick, if FIFO is empty: hold the last daout_data, pulse underflow for 1 cycle, and increment underflow_count (saturate at 16'hFFFF). Stay in RUN; resume popping at the next tick with data. No re-priming.
  - enable=0 is honoured only at the next update tick: that tick does not pop, sets daout_data=MIDSCALE and daclk=0, and goes to IDLE. FIFO contents are retained.
- clk_div is sampled at each terminal count. A change mid-period takes effect from the next count period.
- underflow_count clears only on reset.

Decomposition:
- Package dac_tx_pkg holds:
  - DATA_W and MIDSCALE defaults;
  - the state encoding (IDLE, PRIME, RUN);
  - the underflow counter width (16).
- One sub-module, sync_fifo: parameterised DATA_W/DEPTH, single clock, synchronous active-high reset. It exposes push, pop, dout (head, first-word-fall-through), full, empty and level.
- Divider, FSM and underflow logic live in dac_stream_tx.

Test Plan:
- Reset/idle: assert reset for 3 cycles, with enable=0 and no pushes. Expect daout_data=8'h80, daclk=0, s_ready=1, fifo_level=0, underflow_count=0, held indefinitely.
- Prime and stream: clk_div=2, enable=1, push 0x01..0x10 at full rate.
  - No daclk activity until fifo_level reaches 8.
  - Then daout_data=0x01, rising edge 2 cycles later, period 4 cycles.
  - Values 0x01..0x10 appear in order, each stable at every rising edge.
- Full/backpressure: enable=0, push 20 samples with s_valid held high. Expect s_ready=0 after the 16th accept, fifo_level=16, and samples 17-20 not stored.
- Underflow: stream with clk_div=1 and stop pushing after 9 samples.
  - The tick after the last pop holds the last value and pulses underflow.
  - underflow_count increments once per empty tick.
  - A new push resumes output at the next tick.
- Disable mid-stream: drop enable midway through a daclk-high phase.
  - daclk completes its high phase; at that falling edge daout_data=8'h80 and state=IDLE.
  - Remaining FIFO contents are retained and fifo_level is unchanged.
- Reset mid-stream plus clk_div=0:
  - Assert reset while in RUN with 5 entries buffered: all outputs return to reset values and fifo_level=0.
  - Restart with clk_div=0: daclk period is 2 cycles.
